// File: rtl/ifu_fetch_if.sv
// Fetch-unit bundle: memory read channel toward the bus, instruction channel toward decode.
// master = fetch unit, slave = memory/decode environment.
interface ifu_fetch_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] npc;
  logic        npc_valid;
  logic        fetch_fault;

  modport master (
    output araddr, arvalid, rready, inst, pc, inst_valid, fetch_fault,
    input  arready, rdata, rresp, rvalid, inst_ready, npc, npc_valid
  );

  modport slave (
    input  araddr, arvalid, rready, inst, pc, inst_valid, fetch_fault,
    output arready, rdata, rresp, rvalid, inst_ready, npc, npc_valid
  );
endinterface

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch: AR -> R -> OUT -> (WAIT_PC), inst_valid 2 cycles after AR at best;
// every handshake output is a registered-state decode. YSYX_23060059_IFU_RRESP_CHECK_EN enables rresp faulting.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h80000000,
  parameter logic [31:0] FAULT_INST = 32'h00100073
) (
  input  logic        clk,
  input  logic        rst_n,
  ifu_fetch_if.master bus
);

  typedef enum logic [2:0] {
    BOOT    = 3'd0,
    AR      = 3'd1,
    R       = 3'd2,
    OUT     = 3'd3,
    WAIT_PC = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        fault_q, fault_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    case (state_q)
      BOOT: state_d = AR;
      AR: begin
        if (bus.arready) state_d = R;
      end
      R: begin
        if (bus.rvalid) begin
          state_d = OUT;
`ifdef YSYX_23060059_IFU_RRESP_CHECK_EN
          if (bus.rresp != 2'b00) begin
            inst_d  = FAULT_INST;
            fault_d = 1'b1;
          end else begin
            inst_d  = bus.rdata;
            fault_d = 1'b0;
          end
`else
          inst_d  = bus.rdata;
          fault_d = 1'b0;
`endif
        end
      end
      OUT: begin
        // A redirect arriving with the consume skips the WAIT_PC bubble.
        if (bus.inst_ready) begin
          if (bus.npc_valid) begin
            pc_d    = bus.npc;
            state_d = AR;
          end else begin
            state_d = WAIT_PC;
          end
        end
      end
      WAIT_PC: begin
        if (bus.npc_valid) begin
          pc_d    = bus.npc;
          state_d = AR;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign bus.araddr     = pc_q;
  assign bus.arvalid    = (state_q == AR);
  assign bus.rready     = (state_q == R);
  assign bus.inst_valid = (state_q == OUT);
  assign bus.inst       = inst_q;
  assign bus.pc         = pc_q;

`ifdef YSYX_23060059_IFU_RRESP_CHECK_EN
  assign bus.fetch_fault = fault_q;
`else
  // Response code and fault word have no consumer in this build.
  logic unused_cfg;
  assign unused_cfg      = ^{bus.rresp, FAULT_INST, fault_q};
  assign bus.fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: expected {pc, inst, fault} pushed when read data is driven, popped in OUT.
module tb_ifu_fetch;
  localparam logic [31:0] RESET_PC   = 32'h80000000;
  localparam logic [31:0] FAULT_INST = 32'h00100073;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifu_fetch_if bus ();

  ifu_fetch #(.RESET_PC(RESET_PC), .FAULT_INST(FAULT_INST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_pc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ar(output bit to);
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.arvalid) begin
        to = 1'b0;
        break;
      end
      tick();
    end
  endtask

  // Address phase with optional arready stall; npc pulses during the stall must be ignored.
  task automatic serve_ar(input int stall, output logic [31:0] addr, output bit stable, output bit to);
    wait_ar(to);
    addr   = bus.araddr;
    stable = !to && !bus.rready;
    for (int i = 0; i < stall; i++) begin
      bus.arready   = 1'b0;
      bus.npc_valid = 1'b1;
      bus.npc       = 32'h12345678;
      tick();
      bus.npc_valid = 1'b0;
      if (!bus.arvalid || bus.araddr !== addr || bus.rready) stable = 1'b0;
    end
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
  endtask

  task automatic serve_r(input int delay, input logic [31:0] data, input logic [1:0] resp, output bit rr_ok);
    exp_t e;
    rr_ok = bus.rready && !bus.arvalid;
    for (int i = 0; i < delay; i++) begin
      bus.npc_valid = 1'b1;
      bus.npc       = 32'h0badc0de;
      tick();
      bus.npc_valid = 1'b0;
      if (!bus.rready) rr_ok = 1'b0;
    end
    e.pc = exp_pc;
`ifdef YSYX_23060059_IFU_RRESP_CHECK_EN
    e.fault = (resp != 2'b00);
    e.inst  = e.fault ? FAULT_INST : data;
`else
    e.fault = 1'b0;
    e.inst  = data;
`endif
    sb.push_back(e);
    bus.rvalid = 1'b1;
    bus.rdata  = data;
    bus.rresp  = resp;
    tick();
    bus.rvalid = 1'b0;
    bus.rresp  = 2'b00;
    if (bus.rready) rr_ok = 1'b0;
  endtask

  task automatic consume(input bit with_npc, input logic [31:0] npc);
    bus.inst_ready = 1'b1;
    bus.npc_valid  = with_npc;
    bus.npc        = npc;
    tick();
    bus.inst_ready = 1'b0;
    bus.npc_valid  = 1'b0;
    if (with_npc) exp_pc = npc;
  endtask

  task automatic redirect(input logic [31:0] npc);
    bus.npc_valid = 1'b1;
    bus.npc       = npc;
    tick();
    bus.npc_valid = 1'b0;
    exp_pc = npc;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({bus.arvalid, bus.rready, bus.inst_valid} !== 3'b000) begin
      failures++;
      $display("FAIL reset_hs got=%b want=000", {bus.arvalid, bus.rready, bus.inst_valid});
    end
    checks++;
    if (bus.inst !== 32'h0 || bus.fetch_fault !== 1'b0 || bus.pc !== RESET_PC) begin
      failures++;
      $display("FAIL reset_regs inst=%h fault=%b pc=%h want 0/0/%h", bus.inst, bus.fetch_fault, bus.pc, RESET_PC);
    end
    rst_n  = 1'b1;
    exp_pc = RESET_PC;
    checks++;
    if (bus.arvalid !== 1'b0) begin
      failures++;
      $display("FAIL boot_arvalid got=%b want=0", bus.arvalid);
    end
    tick();
    checks++;
    if (bus.arvalid !== 1'b1 || bus.araddr !== RESET_PC) begin
      failures++;
      $display("FAIL boot_to_ar arvalid=%b araddr=%h want 1/%h", bus.arvalid, bus.araddr, RESET_PC);
    end
  endtask

  task automatic test_basic();
    logic [31:0] a;
    bit st, to, rr;
    exp_t e;
    serve_ar(0, a, st, to);
    checks++;
    if (to || a !== 32'h80000000) begin
      failures++;
      $display("FAIL basic_araddr got=%h timeout=%0d want=80000000", a, to);
    end
    serve_r(0, 32'h00000413, 2'b00, rr);
    e = sb.pop_front();
    checks++;
    if (bus.inst_valid !== 1'b1 || {bus.pc, bus.inst, bus.fetch_fault} !== e) begin
      failures++;
      $display("FAIL basic_out vld=%b pc=%h inst=%h flt=%b want pc=%h inst=%h flt=%b",
               bus.inst_valid, bus.pc, bus.inst, bus.fetch_fault, e.pc, e.inst, e.fault);
    end
    consume(1'b0, 32'h0);
    checks++;
    if (bus.arvalid !== 1'b0 || bus.inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_wait_pc arvalid=%b inst_valid=%b want 0/0", bus.arvalid, bus.inst_valid);
    end
    redirect(32'h80000004);
  endtask

  task automatic test_stall();
    logic [31:0] a;
    bit st, to, rr;
    int vld_cnt;
    exp_t e;
    serve_ar(3, a, st, to);
    checks++;
    if (!st || a !== 32'h80000004) begin
      failures++;
      $display("FAIL stall_ar stable=%0d araddr=%h want 1/80000004", st, a);
    end
    serve_r(2, 32'h00a00093, 2'b00, rr);
    checks++;
    if (!rr) begin
      failures++;
      $display("FAIL stall_rready got=0 want=1 (rready outside R or missing in R)");
    end
    e = sb.pop_front();
    checks++;
    if (bus.inst_valid !== 1'b1 || {bus.pc, bus.inst, bus.fetch_fault} !== e) begin
      failures++;
      $display("FAIL stall_out pc=%h inst=%h want pc=%h inst=%h", bus.pc, bus.inst, e.pc, e.inst);
    end
    consume(1'b0, 32'h0);
    vld_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.inst_valid) vld_cnt++;
      tick();
    end
    checks++;
    if (vld_cnt != 0) begin
      failures++;
      $display("FAIL stall_one_period extra inst_valid cycles got=%0d want=0", vld_cnt);
    end
    redirect(32'h80000008);
  endtask

  task automatic test_hold();
    logic [31:0] a;
    bit st, to, rr, held, waited;
    exp_t e;
    serve_ar(0, a, st, to);
    serve_r(0, 32'h00208133, 2'b00, rr);
    e = sb.pop_front();
    held = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.inst_ready = 1'b0;
      bus.npc_valid  = (i % 2 == 0);
      bus.npc        = 32'h80001000;
      tick();
      bus.npc_valid  = 1'b0;
      if (bus.inst_valid !== 1'b1 || {bus.pc, bus.inst, bus.fetch_fault} !== e) held = 1'b0;
    end
    checks++;
    if (!held) begin
      failures++;
      $display("FAIL hold_stable pc=%h inst=%h want pc=%h inst=%h", bus.pc, bus.inst, e.pc, e.inst);
    end
    consume(1'b0, 32'h0);
    waited = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (bus.arvalid || bus.inst_valid) waited = 1'b0;
      tick();
    end
    checks++;
    if (!waited) begin
      failures++;
      $display("FAIL hold_wait_pc left WAIT_PC without npc_valid got=1 want=0");
    end
    redirect(32'h8000000c);
    checks++;
    if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h8000000c) begin
      failures++;
      $display("FAIL hold_redirect arvalid=%b araddr=%h want 1/8000000c", bus.arvalid, bus.araddr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    bit st, to, rr;
    exp_t e;
    serve_ar(0, a, st, to);
    serve_r(0, 32'h40110133, 2'b00, rr);
    e = sb.pop_front();
    checks++;
    if ({bus.pc, bus.inst, bus.fetch_fault} !== e) begin
      failures++;
      $display("FAIL b2b_out pc=%h inst=%h want pc=%h inst=%h", bus.pc, bus.inst, e.pc, e.inst);
    end
    consume(1'b1, 32'h80000010);
    checks++;
    if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h80000010) begin
      failures++;
      $display("FAIL b2b_ar arvalid=%b araddr=%h want 1/80000010", bus.arvalid, bus.araddr);
    end
  endtask

  task automatic test_fault();
    logic [31:0] a;
    bit st, to, rr;
    exp_t e;
    serve_ar(0, a, st, to);
    serve_r(0, 32'hdeadbeef, 2'b10, rr);
    e = sb.pop_front();
    checks++;
    if ({bus.pc, bus.inst, bus.fetch_fault} !== e) begin
      failures++;
      $display("FAIL fault_resp inst=%h flt=%b want inst=%h flt=%b", bus.inst, bus.fetch_fault, e.inst, e.fault);
    end
    consume(1'b0, 32'h0);
    redirect(32'h80000014);
    serve_ar(0, a, st, to);
    serve_r(0, 32'h00000013, 2'b00, rr);
    e = sb.pop_front();
    checks++;
    if ({bus.pc, bus.inst, bus.fetch_fault} !== e) begin
      failures++;
      $display("FAIL fault_clear pc=%h inst=%h flt=%b want pc=%h inst=%h flt=0", bus.pc, bus.inst, bus.fetch_fault, e.pc, e.inst);
    end
    consume(1'b0, 32'h0);
    redirect(32'h80000018);
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    bit st, to, rr;
    exp_t e;
    serve_ar(0, a, st, to);
    checks++;
    if (bus.rready !== 1'b1 || a !== 32'h80000018) begin
      failures++;
      $display("FAIL rstmid_in_r rready=%b araddr=%h want 1/80000018", bus.rready, a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.arvalid, bus.rready, bus.inst_valid, bus.fetch_fault} !== 4'b0000 ||
        bus.inst !== 32'h0 || bus.pc !== RESET_PC) begin
      failures++;
      $display("FAIL rstmid_async hs=%b inst=%h pc=%h want 0000/0/%h",
               {bus.arvalid, bus.rready, bus.inst_valid, bus.fetch_fault}, bus.inst, bus.pc, RESET_PC);
    end
    tick();
    rst_n  = 1'b1;
    exp_pc = RESET_PC;
    serve_ar(0, a, st, to);
    checks++;
    if (to || a !== 32'h80000000) begin
      failures++;
      $display("FAIL rstmid_restart araddr=%h timeout=%0d want=80000000", a, to);
    end
    serve_r(0, 32'h00100093, 2'b00, rr);
    e = sb.pop_front();
    checks++;
    if (bus.inst_valid !== 1'b1 || {bus.pc, bus.inst, bus.fetch_fault} !== e) begin
      failures++;
      $display("FAIL rstmid_out pc=%h inst=%h want pc=%h inst=%h", bus.pc, bus.inst, e.pc, e.inst);
    end
  endtask

  initial begin
    bus.arready    = 1'b0;
    bus.rdata      = 32'h0;
    bus.rresp      = 2'b00;
    bus.rvalid     = 1'b0;
    bus.inst_ready = 1'b0;
    bus.npc        = 32'h0;
    bus.npc_valid  = 1'b0;
    exp_pc         = RESET_PC;
    test_reset();
    test_basic();
    test_stall();
    test_hold();
    test_back_to_back();
    test_fault();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish got=timeout want=finish");
    $fatal(1);
  end
endmodule
